// File: rtl/renkon_ctrl_serial.sv
// Sequencer for the 8-bank serial output matrix: broadcast-writes one word per core per beat,
// then drains the banks one after another into a single tagged serial stream.
module renkon_ctrl_serial #(
    parameter int CORE    = 8,
    parameter int CORELOG = 3,
    parameter int OUTSIZE = 12
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               start,
    input  logic [OUTSIZE:0]   out_size,
    input  logic               in_valid,
    output logic               busy,
    output logic               serial_we,
    output logic [OUTSIZE-1:0] serial_addr,
    output logic [CORELOG:0]   serial_re,
    output logic               out_valid,
    output logic [CORELOG-1:0] out_core,
    output logic [OUTSIZE-1:0] out_addr,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [OUTSIZE:0]   MAX_N     = {1'b1, {OUTSIZE{1'b0}}};
    localparam logic [OUTSIZE:0]   N_ONE     = (OUTSIZE+1)'(1);
    localparam logic [CORELOG-1:0] LAST_BANK = CORELOG'(CORE - 1);

    state_t               state_q;
    logic [OUTSIZE:0]     n_q;
    logic [OUTSIZE-1:0]   wcnt_q;
    logic [OUTSIZE-1:0]   raddr_q;
    logic [CORELOG-1:0]   bank_q;
    logic                 drain_q;
    logic                 busy_q;
    logic                 done_q;
    // Read tags travel alongside the bank RAM register and the output mux register.
    logic                 tag_v1_q;
    logic [CORELOG-1:0]   tag_core1_q;
    logic [OUTSIZE-1:0]   tag_addr1_q;
    logic                 out_valid_q;
    logic [CORELOG-1:0]   out_core_q;
    logic [OUTSIZE-1:0]   out_addr_q;

    logic [OUTSIZE:0]     n_d;
    logic                 last_w;
    logic                 last_r;
    logic                 issue;

    assign n_d    = (out_size > MAX_N) ? MAX_N : out_size;
    assign last_w = ({1'b0, wcnt_q} == n_q - N_ONE);
    assign last_r = ({1'b0, raddr_q} == n_q - N_ONE);
    assign issue  = (state_q == READ);

    always_ff @(posedge clk) begin
        // NOTE: every register, including the tag pipeline, is cleared so an aborted job
        // cannot leak a stale out_valid or done after reset.
        if (xrst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            wcnt_q      <= '0;
            raddr_q     <= '0;
            bank_q      <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag_v1_q    <= 1'b0;
            tag_core1_q <= '0;
            tag_addr1_q <= '0;
            out_valid_q <= 1'b0;
            out_core_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            tag_v1_q    <= issue;
            tag_core1_q <= issue ? bank_q : '0;
            tag_addr1_q <= issue ? raddr_q : '0;
            out_valid_q <= tag_v1_q;
            out_core_q  <= tag_core1_q;
            out_addr_q  <= tag_addr1_q;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q     <= n_d;
                        wcnt_q  <= '0;
                        raddr_q <= '0;
                        bank_q  <= '0;
                        busy_q  <= 1'b1;
                        if (n_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (in_valid) begin
                        if (last_w) begin
                            state_q <= READ;
                            wcnt_q  <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + OUTSIZE'(1);
                        end
                    end
                end
                READ: begin
                    if (!last_r) begin
                        raddr_q <= raddr_q + OUTSIZE'(1);
                    end else if (bank_q != LAST_BANK) begin
                        raddr_q <= '0;
                        bank_q  <= bank_q + CORELOG'(1);
                    end else begin
                        // bank/raddr stay put so the output mux select is stable while draining
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    bank_q  <= '0;
                    raddr_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        serial_we   = 1'b0;
        serial_addr = '0;
        serial_re   = '0;
        case (state_q)
            WRITE: begin
                serial_we   = in_valid;
                serial_addr = wcnt_q;
            end
            READ, DRAIN: begin
                serial_addr = raddr_q;
                serial_re   = (CORELOG+1)'(bank_q) + (CORELOG+1)'(1);
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_core  = out_core_q;
    assign out_addr  = out_addr_q;

endmodule
